// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared state encoding and constants for the duty-cycle clock generator
package clkgen_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, HIGH = 2'b01, LOW = 2'b10} state_t;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_PCNT_W = 16;
    localparam int MIN_PHASE = 1;
endpackage

// File: rtl/duty_cycle_clkgen_ctrl_if.sv
// duty_cycle_clkgen_ctrl_if: configuration handshake between the config layer and the clock generator
interface duty_cycle_clkgen_ctrl_if import clkgen_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
    logic cfg_valid;
    logic cfg_ready;
    logic cfg_err;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    modport master (output cfg_valid, cfg_high, cfg_low, input cfg_ready, cfg_err);
    modport slave (input cfg_valid, cfg_high, cfg_low, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkgen_cfg_shadow.sv
// clkgen_cfg_shadow: accepts and validates a new phase configuration and holds it until a period boundary
module clkgen_cfg_shadow import clkgen_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic apply_ok,
    duty_cycle_clkgen_ctrl_if.slave cfg,
    output logic apply,
    output logic [CNT_W-1:0] pend_high,
    output logic [CNT_W-1:0] pend_low
);
    logic pending, xfer, zero;
    always_comb begin
        xfer = cfg.cfg_valid && cfg.cfg_ready;
        zero = cfg.cfg_high < CNT_W'(MIN_PHASE) || cfg.cfg_low < CNT_W'(MIN_PHASE);
        apply = pending && apply_ok;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err <= 1'b0;
            pend_high <= '0;
            pend_low <= '0;
        end else begin
            cfg.cfg_err <= xfer && zero;
            if (apply) begin
                pending <= 1'b0;
                cfg.cfg_ready <= 1'b1;
            end else if (xfer && !zero) begin
                pending <= 1'b1;
                cfg.cfg_ready <= 1'b0;
                pend_high <= cfg.cfg_high;
                pend_low <= cfg.cfg_low;
            end
        end
    end
endmodule

// File: rtl/duty_cycle_clkgen_ctrl.sv
// duty_cycle_clkgen_ctrl: divides clk into clk_out with programmable HIGH/LOW phase lengths, glitch-free reconfiguration
module duty_cycle_clkgen_ctrl import clkgen_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEF_HIGH = 6,
    parameter int DEF_LOW = 4,
    parameter int PCNT_W = DEF_PCNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    duty_cycle_clkgen_ctrl_if.slave cfg,
    output logic clk_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy,
    output logic [PCNT_W-1:0] period_cnt
);
    state_t state, state_nx;
    logic [CNT_W-1:0] ph_cnt, ph_nx, act_high, act_low, pend_high, pend_low;
    logic hi_done, boundary, apply;
    always_comb begin
        hi_done = state == HIGH && ph_cnt == act_high;
        boundary = state == LOW && ph_cnt == act_low;
        state_nx = (state == IDLE || boundary) ? (en ? HIGH : IDLE) : hi_done ? LOW : state;
        ph_nx = (state_nx != state || state == IDLE) ? CNT_W'(1) : ph_cnt + CNT_W'(1);
    end
    clkgen_cfg_shadow #(.CNT_W(CNT_W)) u_shadow (
        .clk(clk),
        .rst_n(rst_n),
        .apply_ok(state == IDLE || boundary),
        .cfg(cfg),
        .apply(apply),
        .pend_high(pend_high),
        .pend_low(pend_low)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ph_cnt <= '0;
            clk_out <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy <= 1'b0;
            period_cnt <= '0;
            act_high <= CNT_W'(DEF_HIGH);
            act_low <= CNT_W'(DEF_LOW);
        end else begin
            state <= state_nx;
            ph_cnt <= ph_nx;
            clk_out <= state_nx == HIGH;
            rise_pulse <= state_nx == HIGH && state != HIGH;
            fall_pulse <= state_nx == LOW && state == HIGH;
            busy <= state_nx != IDLE;
            period_cnt <= period_cnt + PCNT_W'(boundary);
            if (apply) begin
                act_high <= pend_high;
                act_low <= pend_low;
            end
        end
    end
endmodule

// File: tb/tb_duty_cycle_clkgen_ctrl.sv
// tb_duty_cycle_clkgen_ctrl: directed scoreboard bench comparing the clk_out waveform and status outputs cycle by cycle
module tb_duty_cycle_clkgen_ctrl;
    logic clk = 1'b0;
    logic rst_n, en, clk_out, rise_pulse, fall_pulse, busy;
    logic [3:0] period_cnt;
    logic [3:0] exp_q[$];
    logic [3:0] ent;
    int n_vec = 0;
    int n_err = 0;
    duty_cycle_clkgen_ctrl_if #(.CNT_W(8)) cif ();
    duty_cycle_clkgen_ctrl #(.CNT_W(8), .DEF_HIGH(6), .DEF_LOW(4), .PCNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .cfg(cif),
        .clk_out(clk_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy(busy),
        .period_cnt(period_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            chk("wave{busy,clk_out,rise,fall}", {28'd0, busy, clk_out, rise_pulse, fall_pulse}, {28'd0, ent});
        end
    endtask
    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask
    task automatic push_period(input int h, input int l);
        for (int i = 0; i < h; i++) exp_q.push_back({1'b1, 1'b1, i == 0, 1'b0});
        for (int i = 0; i < l; i++) exp_q.push_back({1'b1, 1'b0, 1'b0, i == 0});
    endtask
    task automatic offer(input logic [7:0] h, input logic [7:0] l);
        cif.cfg_valid = 1'b1;
        cif.cfg_high = h;
        cif.cfg_low = l;
    endtask
    task automatic chk_reset_vals();
        chk("rst_clk_out", {31'd0, clk_out}, 0);
        chk("rst_rise", {31'd0, rise_pulse}, 0);
        chk("rst_fall", {31'd0, fall_pulse}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_cfg_ready", {31'd0, cif.cfg_ready}, 1);
        chk("rst_cfg_err", {31'd0, cif.cfg_err}, 0);
        chk("rst_period_cnt", {28'd0, period_cnt}, 0);
    endtask
    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_high = '0;
        cif.cfg_low = '0;
        step_n(2);
        chk_reset_vals();
        rst_n = 1'b1;
        step();
        // default 6/4 run; 3/1 accepted mid-HIGH applies only from the next period
        en = 1'b1;
        push_period(6, 4);
        step();
        chk("p1_period_cnt_c1", {28'd0, period_cnt}, 0);
        step();
        offer(8'd3, 8'd1);
        push_period(3, 1);
        step();
        chk("acc_ready_low", {31'd0, cif.cfg_ready}, 0);
        cif.cfg_valid = 1'b0;
        step_n(7);
        chk("c10_period_cnt", {28'd0, period_cnt}, 0);
        chk("c10_ready_low", {31'd0, cif.cfg_ready}, 0);
        step();
        chk("c11_period_cnt", {28'd0, period_cnt}, 1);
        chk("c11_ready_back", {31'd0, cif.cfg_ready}, 1);
        offer(8'd0, 8'd5);
        step();
        chk("zero_cfg_err", {31'd0, cif.cfg_err}, 1);
        chk("zero_cfg_ready", {31'd0, cif.cfg_ready}, 1);
        cif.cfg_valid = 1'b0;
        step();
        chk("zero_err_pulse_end", {31'd0, cif.cfg_err}, 0);
        en = 1'b0;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        step_n(2);
        chk("stop_busy", {31'd0, busy}, 0);
        chk("stop_period_cnt", {28'd0, period_cnt}, 2);
        step();
        // config applied directly while idle
        offer(8'd2, 8'd8);
        step();
        chk("idle_acc_ready", {31'd0, cif.cfg_ready}, 0);
        cif.cfg_valid = 1'b0;
        step();
        chk("idle_apply_ready", {31'd0, cif.cfg_ready}, 1);
        en = 1'b1;
        push_period(2, 8);
        step();
        offer(8'd5, 8'd5);
        step();
        chk("run2_acc_ready", {31'd0, cif.cfg_ready}, 0);
        cif.cfg_valid = 1'b0;
        step_n(2);
        chk("mid_low_clk_out", {31'd0, clk_out}, 0);
        // reset mid-LOW drops the pending 5/5
        rst_n = 1'b0;
        en = 1'b0;
        exp_q.delete();
        step();
        chk_reset_vals();
        rst_n = 1'b1;
        en = 1'b1;
        push_period(6, 4);
        exp_q.push_back(4'b0000);
        step();
        en = 1'b0;
        step_n(10);
        chk("post_rst_period_cnt", {28'd0, period_cnt}, 1);
        chk("post_rst_busy", {31'd0, busy}, 0);
        // 1/1 for 16 periods wraps the 4-bit period counter
        offer(8'd1, 8'd1);
        step();
        cif.cfg_valid = 1'b0;
        step();
        en = 1'b1;
        for (int k = 0; k < 16; k++) push_period(1, 1);
        step_n(29);
        chk("wrap_pc15", {28'd0, period_cnt}, 15);
        step_n(2);
        chk("wrap_pc0", {28'd0, period_cnt}, 0);
        en = 1'b0;
        exp_q.push_back(4'b0000);
        step_n(2);
        chk("wrap_final_pc", {28'd0, period_cnt}, 1);
        chk("wrap_final_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
